controlador_cursor_grid: RTL and testbench

//  Parametrised cursor controller for the VGA board-selection UI. Takes raw push-buttons,

---
 rtl/cursor_pkg.sv | 17 +
 rtl/antirebote_boton.sv | 45 ++++
 rtl/controlador_cursor_grid.sv | 128 ++++++++++++
 tb/tb_controlador_cursor_grid.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// rtl/cursor_pkg.sv - shared types and width helper for the grid cursor controller
package cursor_pkg;

  localparam int DEBOUNCE_DEFAULT = 250000;

  typedef enum logic [1:0] {
    MV_NONE,
    MV_NEXT,
    MV_PREV
  } mov_t;

  // Width of a field holding 0..v-1; never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/antirebote_boton.sv
// rtl/antirebote_boton.sv - button synchroniser, debouncer and registered press pulse
module antirebote_boton
  import cursor_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton,
  output logic pulso
);

  localparam int CNT_W = clog2_min1(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_a;
  logic             sync_b;
  logic             nivel;
  logic [CNT_W-1:0] cnt;

  // The pulse is registered together with the level flip, so the cursor moves one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      nivel  <= 1'b0;
      cnt    <= '0;
      pulso  <= 1'b0;
    end else begin
      sync_a <= boton;
      sync_b <= sync_a;
      pulso  <= 1'b0;
      if (sync_b == nivel) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        nivel <= sync_b;
        pulso <= sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/controlador_cursor_grid.sv
// rtl/controlador_cursor_grid.sv - debounced cursor over a COLS x ROWS grid for the VGA board UI
module controlador_cursor_grid
  import cursor_pkg::*;
#(
  parameter int COLS         = 4,
  parameter int ROWS         = 4,
  parameter int DEBOUNCE_CYC = DEBOUNCE_DEFAULT,
  parameter int WRAP         = 1,
  parameter int STEP_ROW     = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              boton_next,
  input  logic                              boton_prev,
  input  logic                              boton_select,
  input  logic                              enable,
  output logic [clog2_min1(COLS*ROWS)-1:0] pos_cursor,
  output logic [clog2_min1(COLS)-1:0]      cursor_col,
  output logic [clog2_min1(ROWS)-1:0]      cursor_row,
  output logic                              select_pulse,
  output logic [clog2_min1(COLS*ROWS)-1:0] pos_selected,
  output logic                              wrap_pulse
);

  localparam int N  = COLS * ROWS;
  localparam int PW = clog2_min1(N);
  localparam int CW = clog2_min1(COLS);
  localparam int RW = clog2_min1(ROWS);

  // One extra bit so pos+step and pos+N-step never overflow.
  localparam logic [PW:0] N_X = (PW+1)'(N);
  localparam logic [PW:0] S_X = (PW+1)'((STEP_ROW != 0) ? COLS : 1);
  localparam logic [PW:0] C_X = (PW+1)'(COLS);

  logic          ev_next;
  logic          ev_prev;
  logic          ev_sel;
  mov_t          mov;
  logic [PW:0]   pos_x;
  logic [PW:0]   sum_x;
  logic [PW-1:0] pos_nx;
  logic [CW-1:0] col_nx;
  logic [RW-1:0] row_nx;
  logic          wrap_nx;

  antirebote_boton #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ab_next (
    .clk   (clk),
    .rst_n (rst_n),
    .boton (boton_next),
    .pulso (ev_next)
  );

  antirebote_boton #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ab_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .boton (boton_prev),
    .pulso (ev_prev)
  );

  antirebote_boton #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ab_select (
    .clk   (clk),
    .rst_n (rst_n),
    .boton (boton_select),
    .pulso (ev_sel)
  );

  // Opposing presses landing in the same cycle cancel out.
  always_comb begin
    mov = MV_NONE;
    if (enable && ev_next && !ev_prev) begin
      mov = MV_NEXT;
    end else if (enable && ev_prev && !ev_next) begin
      mov = MV_PREV;
    end
  end

  always_comb begin
    pos_x   = {1'b0, pos_cursor};
    sum_x   = '0;
    pos_nx  = pos_cursor;
    wrap_nx = 1'b0;
    case (mov)
      MV_NEXT: begin
        sum_x = pos_x + S_X;
        if (sum_x < N_X) begin
          pos_nx = sum_x[PW-1:0];
        end else if (WRAP != 0) begin
          pos_nx  = PW'(sum_x - N_X);
          wrap_nx = 1'b1;
        end
      end
      MV_PREV: begin
        if (pos_x >= S_X) begin
          pos_nx = PW'(pos_x - S_X);
        end else if (WRAP != 0) begin
          sum_x   = pos_x + N_X - S_X;
          pos_nx  = sum_x[PW-1:0];
          wrap_nx = 1'b1;
        end
      end
      default: begin
      end
    endcase
    col_nx = CW'({1'b0, pos_nx} % C_X);
    row_nx = RW'({1'b0, pos_nx} / C_X);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_cursor   <= '0;
      cursor_col   <= '0;
      cursor_row   <= '0;
      select_pulse <= 1'b0;
      pos_selected <= '0;
      wrap_pulse   <= 1'b0;
    end else begin
      pos_cursor   <= pos_nx;
      cursor_col   <= col_nx;
      cursor_row   <= row_nx;
      wrap_pulse   <= wrap_nx;
      select_pulse <= enable & ev_sel;
      if (enable && ev_sel) begin
        pos_selected <= pos_cursor;
      end
    end
  end

endmodule

// File: tb/tb_controlador_cursor_grid.sv
// tb/tb_controlador_cursor_grid.sv - randomized bench for the grid cursor against a behavioural model
`timescale 1ns/1ps
module tb_controlador_cursor_grid;

  localparam int D  = 4;
  localparam int NI = 4;
  localparam int COLS_P [NI] = '{4, 4, 4, 1};
  localparam int ROWS_P [NI] = '{4, 4, 4, 1};
  localparam int WRAP_P [NI] = '{1, 0, 1, 1};
  localparam int STEP_P [NI] = '{0, 0, 1, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b_next = 1'b0;
  logic b_prev = 1'b0;
  logic b_sel = 1'b0;
  logic enable = 1'b1;

  logic [3:0] pos_a, ps_a, pos_b, ps_b, pos_c, ps_c;
  logic [1:0] col_a, row_a, col_b, row_b, col_c, row_c;
  logic       sp_a, wp_a, sp_b, wp_b, sp_c, wp_c;
  logic       pos_d, ps_d, col_d, row_d, sp_d, wp_d;

  int g_pos [NI];
  int g_col [NI];
  int g_row [NI];
  int g_sp  [NI];
  int g_ps  [NI];
  int g_wp  [NI];

  // model state: raw history, debounced levels, pending press events, per-instance cursor
  int r1 [3];
  int r2 [3];
  int lvl [3];
  int run [3];
  int ev [3];
  int m_pos [NI];
  int m_sp  [NI];
  int m_ps  [NI];
  int m_wp  [NI];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  controlador_cursor_grid #(.COLS(4), .ROWS(4), .DEBOUNCE_CYC(D), .WRAP(1), .STEP_ROW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .boton_next(b_next), .boton_prev(b_prev), .boton_select(b_sel),
    .enable(enable), .pos_cursor(pos_a), .cursor_col(col_a), .cursor_row(row_a),
    .select_pulse(sp_a), .pos_selected(ps_a), .wrap_pulse(wp_a));

  controlador_cursor_grid #(.COLS(4), .ROWS(4), .DEBOUNCE_CYC(D), .WRAP(0), .STEP_ROW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .boton_next(b_next), .boton_prev(b_prev), .boton_select(b_sel),
    .enable(enable), .pos_cursor(pos_b), .cursor_col(col_b), .cursor_row(row_b),
    .select_pulse(sp_b), .pos_selected(ps_b), .wrap_pulse(wp_b));

  controlador_cursor_grid #(.COLS(4), .ROWS(4), .DEBOUNCE_CYC(D), .WRAP(1), .STEP_ROW(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .boton_next(b_next), .boton_prev(b_prev), .boton_select(b_sel),
    .enable(enable), .pos_cursor(pos_c), .cursor_col(col_c), .cursor_row(row_c),
    .select_pulse(sp_c), .pos_selected(ps_c), .wrap_pulse(wp_c));

  controlador_cursor_grid #(.COLS(1), .ROWS(1), .DEBOUNCE_CYC(D), .WRAP(1), .STEP_ROW(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .boton_next(b_next), .boton_prev(b_prev), .boton_select(b_sel),
    .enable(enable), .pos_cursor(pos_d), .cursor_col(col_d), .cursor_row(row_d),
    .select_pulse(sp_d), .pos_selected(ps_d), .wrap_pulse(wp_d));

  always_comb begin
    g_pos[0] = int'(pos_a); g_col[0] = int'(col_a); g_row[0] = int'(row_a);
    g_sp[0]  = int'(sp_a);  g_ps[0]  = int'(ps_a);  g_wp[0]  = int'(wp_a);
    g_pos[1] = int'(pos_b); g_col[1] = int'(col_b); g_row[1] = int'(row_b);
    g_sp[1]  = int'(sp_b);  g_ps[1]  = int'(ps_b);  g_wp[1]  = int'(wp_b);
    g_pos[2] = int'(pos_c); g_col[2] = int'(col_c); g_row[2] = int'(row_c);
    g_sp[2]  = int'(sp_c);  g_ps[2]  = int'(ps_c);  g_wp[2]  = int'(wp_c);
    g_pos[3] = int'(pos_d); g_col[3] = int'(col_d); g_row[3] = int'(row_d);
    g_sp[3]  = int'(sp_d);  g_ps[3]  = int'(ps_d);  g_wp[3]  = int'(wp_d);
  end

  task automatic check(input string name, input int idx, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, idx, got, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour: moves use last edge's events, then debounce.
  task automatic model_step();
    int raw [3];
    int n, s, p;
    raw[0] = int'(b_next);
    raw[1] = int'(b_prev);
    raw[2] = int'(b_sel);
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) begin
        r1[b] = 0; r2[b] = 0; lvl[b] = 0; run[b] = 0; ev[b] = 0;
      end
      for (int i = 0; i < NI; i++) begin
        m_pos[i] = 0; m_sp[i] = 0; m_ps[i] = 0; m_wp[i] = 0;
      end
      return;
    end
    for (int i = 0; i < NI; i++) begin
      n = COLS_P[i] * ROWS_P[i];
      s = (STEP_P[i] != 0) ? COLS_P[i] : 1;
      p = m_pos[i];
      m_sp[i] = 0;
      m_wp[i] = 0;
      if (enable) begin
        if (ev[2] != 0) begin
          m_sp[i] = 1;
          m_ps[i] = p;
        end
        if (ev[0] != 0 && ev[1] == 0) begin
          if (p + s < n) m_pos[i] = p + s;
          else if (WRAP_P[i] != 0) begin m_pos[i] = (p + s) % n; m_wp[i] = 1; end
        end else if (ev[1] != 0 && ev[0] == 0) begin
          if (p - s >= 0) m_pos[i] = p - s;
          else if (WRAP_P[i] != 0) begin m_pos[i] = (p - s + n) % n; m_wp[i] = 1; end
        end
      end
    end
    for (int b = 0; b < 3; b++) begin
      ev[b] = 0;
      if (r2[b] != lvl[b]) begin
        run[b]++;
        if (run[b] == D) begin
          lvl[b] = r2[b];
          run[b] = 0;
          ev[b]  = lvl[b];
        end
      end else begin
        run[b] = 0;
      end
      r2[b] = r1[b];
      r1[b] = raw[b];
    end
  endtask

  initial begin
    for (int b = 0; b < 3; b++) begin
      r1[b] = 0; r2[b] = 0; lvl[b] = 0; run[b] = 0; ev[b] = 0;
    end
    for (int i = 0; i < NI; i++) begin
      m_pos[i] = 0; m_sp[i] = 0; m_ps[i] = 0; m_wp[i] = 0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        check("pos_cursor", i, g_pos[i], m_pos[i]);
        check("cursor_col", i, g_col[i], m_pos[i] % COLS_P[i]);
        check("cursor_row", i, g_row[i], m_pos[i] / COLS_P[i]);
        check("select_pulse", i, g_sp[i], m_sp[i]);
        check("pos_selected", i, g_ps[i], m_ps[i]);
        check("wrap_pulse", i, g_wp[i], m_wp[i]);
      end
    end
  end

  task automatic press(input logic nx, input logic pv, input logic sl, input int hold);
    @(negedge clk);
    b_next = nx; b_prev = pv; b_sel = sl;
    repeat (hold) @(negedge clk);
    b_next = 1'b0; b_prev = 1'b0; b_sel = 1'b0;
    repeat (D + 6) @(negedge clk);
  endtask

  initial begin
    int pat, dur;
    repeat (3) @(negedge clk);
    check("reset_pos", 0, g_pos[0], 0);
    check("reset_select_pulse", 0, g_sp[0], 0);
    check("reset_wrap_pulse", 0, g_wp[0], 0);
    check("reset_pos_selected", 0, g_ps[0], 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // clean press: update exactly 2 + D + 1 edges after the raw edge
    b_next = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t1_pos_before", 0, g_pos[0], 0);
    @(posedge clk);
    #1;
    check("t1_pos", 0, g_pos[0], 1);
    check("t1_col", 0, g_col[0], 1);
    check("t1_row", 0, g_row[0], 0);
    repeat (3) @(negedge clk);
    b_next = 1'b0;
    repeat (D + 8) @(negedge clk);
    check("t1_single_step", 0, g_pos[0], 1);

    // bounce shorter than the debounce window never registers
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      b_next = ((k / 2) % 2 == 0);
    end
    check("t2_bounce_ignored", 0, g_pos[0], 1);
    press(1'b1, 1'b0, 1'b0, 12);
    check("t2_one_step", 0, g_pos[0], 2);

    for (int k = 0; k < 13; k++) press(1'b1, 1'b0, 1'b0, 10);
    check("t3_at_last", 0, g_pos[0], 15);
    check("t3_sat_at_last", 1, g_pos[1], 15);
    @(negedge clk);
    b_next = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("t3_wrap_pos", 0, g_pos[0], 0);
    check("t3_wrap_pulse", 0, g_wp[0], 1);
    check("t3_sat_pos", 1, g_pos[1], 15);
    check("t3_sat_no_wrap", 1, g_wp[1], 0);
    @(posedge clk);
    #1;
    check("t3_wrap_one_cycle", 0, g_wp[0], 0);
    @(negedge clk);
    b_next = 1'b0;
    repeat (D + 6) @(negedge clk);
    @(negedge clk);
    b_prev = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("t3_prev_wrap_pos", 0, g_pos[0], 15);
    check("t3_prev_wrap_pulse", 0, g_wp[0], 1);
    check("t3_prev_sat_step", 1, g_pos[1], 14);
    check("t4_row_wrap_pos", 2, g_pos[2], 12);
    check("t4_row_wrap_col", 2, g_col[2], 0);
    check("t4_row_wrap_row", 2, g_row[2], 3);
    check("t4_row_wrap_pulse", 2, g_wp[2], 1);
    check("n1_pos", 3, g_pos[3], 0);
    check("n1_wrap_pulse", 3, g_wp[3], 1);
    @(negedge clk);
    b_prev = 1'b0;
    repeat (D + 6) @(negedge clk);

    press(1'b1, 1'b1, 1'b0, 10);
    check("t5_both_no_move", 0, g_pos[0], 15);
    for (int k = 0; k < 7; k++) press(1'b1, 1'b0, 1'b0, 10);
    check("t5_at_six", 0, g_pos[0], 6);
    @(negedge clk);
    b_next = 1'b1;
    b_sel = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("t5_sel_pos", 0, g_pos[0], 7);
    check("t5_sel_captured", 0, g_ps[0], 6);
    check("t5_sel_pulse", 0, g_sp[0], 1);
    @(posedge clk);
    #1;
    check("t5_sel_one_cycle", 0, g_sp[0], 0);
    @(negedge clk);
    b_next = 1'b0;
    b_sel = 1'b0;
    repeat (D + 6) @(negedge clk);

    // reset in the middle of a held press, button still held afterwards
    @(negedge clk);
    b_next = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_async_pos", 0, g_pos[0], 0);
    check("t6_async_pos_selected", 0, g_ps[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (D + 2) @(posedge clk);
    #1;
    check("t6_pos_before", 0, g_pos[0], 0);
    @(posedge clk);
    #1;
    check("t6_pos_after", 0, g_pos[0], 1);
    @(negedge clk);
    b_next = 1'b0;
    repeat (D + 6) @(negedge clk);

    enable = 1'b0;
    press(1'b1, 1'b0, 1'b0, 10);
    press(1'b0, 1'b0, 1'b1, 10);
    check("t6_enable_frozen", 0, g_pos[0], 1);
    check("t6_enable_no_capture", 0, g_ps[0], 0);
    @(negedge clk);
    b_next = 1'b1;
    repeat (D + 6) @(negedge clk);
    enable = 1'b1;
    repeat (8) @(negedge clk);
    b_next = 1'b0;
    repeat (D + 6) @(negedge clk);
    check("t6_no_late_event", 0, g_pos[0], 1);

    // random button patterns, enable flips and occasional resets
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      pat = int'($urandom_range(0, 7));
      dur = int'($urandom_range(1, 12));
      b_next = pat[0];
      b_prev = pat[1];
      b_sel  = pat[2];
      enable = ($urandom_range(0, 6) != 0);
      repeat (dur) @(negedge clk);
    end
    b_next = 1'b0;
    b_prev = 1'b0;
    b_sel = 1'b0;
    enable = 1'b1;
    repeat (D + 10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
